// File: rtl/tick_period_meter.sv
// rtl/tick_period_meter.sv - period, min/max and edge-count meter for a pulse or tick stream
//
// Ports:
//   clk, reset     system clock; synchronous active-high reset
//   pulse_in       measured pulse/tick stream, may be asynchronous to clk
//   clear_stats    clears min_period, max_period and edge_count
//   period         last measured rising-edge spacing in clk cycles
//   period_valid   one-cycle strobe, period updated this cycle
//   timeout        level, no rising edge for TIMEOUT_CYCLES cycles
//   min_period     smallest period since reset or clear
//   max_period     largest period since reset or clear
//   edge_count     saturating count of detected rising edges
module tick_period_meter #(
    parameter int CNT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 100_000_000,
    parameter int EDGE_CNT_WIDTH = 16,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pulse_in,
    input  logic                      clear_stats,
    output logic [CNT_WIDTH-1:0]      period,
    output logic                      period_valid,
    output logic                      timeout,
    output logic [CNT_WIDTH-1:0]      min_period,
    output logic [CNT_WIDTH-1:0]      max_period,
    output logic [EDGE_CNT_WIDTH-1:0] edge_count
);

    typedef enum logic [1:0] {
        WAIT_FIRST,
        MEASURE,
        TIMED_OUT
    } state_t;

    localparam logic [CNT_WIDTH-1:0]      TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0]      CNT_ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [EDGE_CNT_WIDTH-1:0] EDGE_ONE    = {{(EDGE_CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   rise;

    state_t                    state, state_next;
    logic [CNT_WIDTH-1:0]      cnt, cnt_next;
    logic [CNT_WIDTH-1:0]      period_next;
    logic                      period_valid_next;
    logic                      timeout_next;
    logic [CNT_WIDTH-1:0]      min_next, max_next;
    logic [EDGE_CNT_WIDTH-1:0] edge_next;

    // Synchronizer chain plus one history flop for rising-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= WAIT_FIRST;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
            min_period   <= '1;
            max_period   <= '0;
            edge_count   <= '0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            period       <= period_next;
            period_valid <= period_valid_next;
            timeout      <= timeout_next;
            min_period   <= min_next;
            max_period   <= max_next;
            edge_count   <= edge_next;
        end
    end

    always_comb begin
        state_next        = state;
        cnt_next          = cnt;
        period_next       = period;
        period_valid_next = 1'b0;
        timeout_next      = timeout;

        // Clear is folded in before the update so a coincident measurement
        // lands on freshly cleared statistics.
        min_next  = clear_stats ? '1 : min_period;
        max_next  = clear_stats ? '0 : max_period;
        edge_next = clear_stats ? '0 : edge_count;

        if (rise && (edge_next != '1)) begin
            edge_next = edge_next + EDGE_ONE;
        end

        case (state)
            WAIT_FIRST: begin
                if (rise) begin
                    cnt_next   = CNT_ONE;
                    state_next = MEASURE;
                end
            end
            MEASURE: begin
                // A rise on the timeout cycle itself still counts as a
                // valid interval of exactly TIMEOUT_CYCLES.
                if (rise) begin
                    period_next       = cnt;
                    period_valid_next = 1'b1;
                    cnt_next          = CNT_ONE;
                    if (cnt < min_next) begin
                        min_next = cnt;
                    end
                    if (cnt > max_next) begin
                        max_next = cnt;
                    end
                end else if (cnt == TIMEOUT_VAL) begin
                    timeout_next = 1'b1;
                    state_next   = TIMED_OUT;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            TIMED_OUT: begin
                // The interval that timed out is meaningless; only restart.
                if (rise) begin
                    timeout_next = 1'b0;
                    cnt_next     = CNT_ONE;
                    state_next   = MEASURE;
                end
            end
            default: begin
                state_next = WAIT_FIRST;
            end
        endcase
    end

endmodule

// File: tb/tb_tick_period_meter.sv
// tb/tb_tick_period_meter.sv - directed self-checking bench for tick_period_meter
module tb_tick_period_meter;

    localparam int CW  = 32;
    localparam int TO  = 50;
    localparam int ECW = 4;
    localparam int SS  = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           pulse_in;
    logic           clear_stats;
    logic [CW-1:0]  period;
    logic           period_valid;
    logic           timeout;
    logic [CW-1:0]  min_period;
    logic [CW-1:0]  max_period;
    logic [ECW-1:0] edge_count;

    tick_period_meter #(
        .CNT_WIDTH      (CW),
        .TIMEOUT_CYCLES (TO),
        .EDGE_CNT_WIDTH (ECW),
        .SYNC_STAGES    (SS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pulse_in     (pulse_in),
        .clear_stats  (clear_stats),
        .period       (period),
        .period_valid (period_valid),
        .timeout      (timeout),
        .min_period   (min_period),
        .max_period   (max_period),
        .edge_count   (edge_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [CW-1:0] pv_q[$];
    int            pv_cyc[$];
    int            b2b = 0;
    logic          prev_pv = 1'b0;

    always @(negedge clk) begin
        if (period_valid) begin
            pv_q.push_back(period);
            pv_cyc.push_back(cyc);
            if (prev_pv) b2b = b2b + 1;
        end
        prev_pv = period_valid;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) tick(1);
    endtask

    task automatic pulse_at(input int t);
        wait_cyc(t);
        pulse_in = 1'b1;
        tick(1);
        pulse_in = 1'b0;
    endtask

    task automatic reset_dut();
        reset       = 1'b1;
        pulse_in    = 1'b0;
        clear_stats = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);
        pv_q.delete();
        pv_cyc.delete();
    endtask

    int t0;

    initial begin
        reset       = 1'b1;
        pulse_in    = 1'b0;
        clear_stats = 1'b0;
        tick(1);

        // Reset held 3 cycles while pulse_in toggles.
        for (int i = 0; i < 3; i++) begin
            pulse_in = ~pulse_in;
            tick(1);
        end
        check("rst_period", period, 0);
        check("rst_valid", period_valid, 0);
        check("rst_timeout", timeout, 0);
        check("rst_min", min_period, 32'hFFFF_FFFF);
        check("rst_max", max_period, 0);
        check("rst_edges", edge_count, 0);
        reset    = 1'b0;
        pulse_in = 1'b0;
        tick(6);
        check("rst_no_strobe", pv_q.size(), 0);
        check("rst_idle_edges", edge_count, 0);

        // Steady ticks: 5 pulses every 6 cycles.
        reset_dut();
        t0 = cyc + 2;
        for (int i = 0; i < 5; i++) pulse_at(t0 + 6 * i);
        wait_cyc(t0 + 6 * 4 + 6);
        check("steady_count", pv_q.size(), 4);
        for (int i = 0; i < pv_q.size(); i++) check("steady_period", pv_q[i], 6);
        if (pv_cyc.size() > 0) check("steady_latency", pv_cyc[0] - (t0 + 6), SS + 1);
        check("steady_min", min_period, 6);
        check("steady_max", max_period, 6);
        check("steady_edges", edge_count, 5);

        // Varying spacing 10, 4, 20.
        reset_dut();
        t0 = cyc + 2;
        pulse_at(t0);
        pulse_at(t0 + 10);
        pulse_at(t0 + 14);
        pulse_at(t0 + 34);
        wait_cyc(t0 + 40);
        check("vary_count", pv_q.size(), 3);
        if (pv_q.size() == 3) begin
            check("vary_p0", pv_q[0], 10);
            check("vary_p1", pv_q[1], 4);
            check("vary_p2", pv_q[2], 20);
        end
        check("vary_min", min_period, 4);
        check("vary_max", max_period, 20);
        check("vary_edges", edge_count, 4);

        // Timeout and recovery.
        reset_dut();
        t0 = cyc + 2;
        pulse_at(t0);
        wait_cyc(t0 + SS + 1 + TO - 1);
        check("to_before", timeout, 0);
        wait_cyc(t0 + SS + 1 + TO);
        check("to_assert", timeout, 1);
        pulse_at(t0 + 70);
        wait_cyc(t0 + 70 + SS);
        check("to_still_high", timeout, 1);
        wait_cyc(t0 + 70 + SS + 1);
        check("to_cleared", timeout, 0);
        check("to_no_strobe", pv_q.size(), 0);
        pulse_at(t0 + 78);
        wait_cyc(t0 + 86);
        check("to_recover_count", pv_q.size(), 1);
        if (pv_q.size() == 1) check("to_recover_period", pv_q[0], 8);
        check("to_edges", edge_count, 3);

        // Rise exactly at cnt == TIMEOUT_CYCLES, then minimum spacing of 2.
        reset_dut();
        t0 = cyc + 2;
        pulse_at(t0);
        pulse_at(t0 + TO);
        pulse_at(t0 + TO + 2);
        wait_cyc(t0 + TO + 10);
        check("edge_to_timeout", timeout, 0);
        check("edge_count_pv", pv_q.size(), 2);
        if (pv_q.size() == 2) begin
            check("edge_p_timeout", pv_q[0], TO);
            check("edge_p_min", pv_q[1], 2);
        end
        check("edge_min", min_period, 2);
        check("edge_max", max_period, TO);

        // Clear coincident with a measurement of 12, then a lone clear.
        reset_dut();
        t0 = cyc + 2;
        pulse_at(t0);
        pulse_at(t0 + 5);
        pulse_at(t0 + 17);
        wait_cyc(t0 + 17 + SS);
        check("clr_pre_max", max_period, 5);
        clear_stats = 1'b1;
        tick(1);
        clear_stats = 1'b0;
        check("clr_co_period", period, 12);
        check("clr_co_min", min_period, 12);
        check("clr_co_max", max_period, 12);
        check("clr_co_edges", edge_count, 1);
        clear_stats = 1'b1;
        tick(1);
        clear_stats = 1'b0;
        check("clr_min", min_period, 32'hFFFF_FFFF);
        check("clr_max", max_period, 0);
        check("clr_edges", edge_count, 0);
        check("clr_period_kept", period, 12);

        // Reset mid-interval discards the partial measurement.
        reset_dut();
        t0 = cyc + 2;
        pulse_at(t0);
        wait_cyc(t0 + 7);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        pv_q.delete();
        t0 = cyc;
        pulse_at(t0 + 5);
        pulse_at(t0 + 10);
        wait_cyc(t0 + 18);
        check("mid_count", pv_q.size(), 1);
        if (pv_q.size() == 1) check("mid_period", pv_q[0], 5);
        check("mid_edges", edge_count, 2);

        // edge_count saturation at all-ones.
        reset_dut();
        t0 = cyc + 2;
        for (int i = 0; i < 20; i++) pulse_at(t0 + 3 * i);
        wait_cyc(t0 + 3 * 19 + 6);
        check("sat_edges", edge_count, 15);
        check("sat_min", min_period, 3);
        check("sat_max", max_period, 3);

        check("no_back_to_back", b2b, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
